// File: rtl/fg_sampler_ctrl_if.sv
// fg_sampler_ctrl_if: keygen/sampler/coef-RAM bundle
// master = keygen top + sampler side, slave = sequencer
interface fg_sampler_ctrl_if #(
   parameter int LOGN   = 9,
   parameter int COEF_W = 8
);
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              gauss_ena;
   logic              gauss_val_valid;
   logic [31:0]       gauss_val;
   logic              coef_we;
   logic              coef_sel;
   logic [LOGN-1:0]   coef_addr;
   logic [COEF_W-1:0] coef_data;

   modport master (
      output start, abort,
      output gauss_val_valid, gauss_val,
      input  busy, done, gauss_ena,
      input  coef_we, coef_sel,
      input  coef_addr, coef_data
   );

   modport slave (
      input  start, abort,
      input  gauss_val_valid, gauss_val,
      output busy, done, gauss_ena,
      output coef_we, coef_sel,
      output coef_addr, coef_data
   );
endinterface

// File: rtl/fg_sampler_ctrl.sv
// fg_sampler_ctrl: fills f then g from the Gaussian sampler
// Option FG_SAMPLER_STATS_EN adds rej_cnt (rejected-sample count)
module fg_sampler_ctrl #(
   parameter int LOGN   = 9,
   parameter int COEF_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   fg_sampler_ctrl_if.slave bus
`ifdef FG_SAMPLER_STATS_EN
   ,
   output logic [15:0] rej_cnt
`endif
);

   function automatic int max_bits(input int l);
      case (l)
         6, 7:    max_bits = 7;
         8, 9:    max_bits = 6;
         10:      max_bits = 5;
         default: max_bits = 8;
      endcase
   endfunction

   localparam int BITS = max_bits(LOGN);
   localparam int LIM1 = (1 << (BITS - 1)) - 1;
   localparam logic [LOGN-1:0] IDX_LAST =
      LOGN'((1 << LOGN) - 1);

   typedef enum logic [1:0] {
      IDLE, GEN_F, GEN_G, FIN
   } state_t;

   state_t            state_q, state_d;
   logic [LOGN-1:0]   idx_q, idx_d;
   logic              mod2_q, mod2_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ena_q, ena_d;
   logic              we_q, we_d;
   logic              sel_q, sel_d;
   logic [LOGN-1:0]   addr_q, addr_d;
   logic [COEF_W-1:0] data_q, data_d;

   logic signed [31:0] s;
   logic               in_bnd;
   logic               in_gen;
   logic               last;
   logic               acc;

   assign s      = signed'(bus.gauss_val);
   assign in_bnd = (s >= -LIM1) && (s <= LIM1);
   assign in_gen = (state_q == GEN_F) ||
                   (state_q == GEN_G);
   assign last   = (idx_q == IDX_LAST);
   // last slot only takes a sample that makes the sum odd
   assign acc    = in_gen && bus.gauss_val_valid &&
                   in_bnd &&
                   (!last || (mod2_q ^ s[0]));

   // next state, index/parity tracking, registered outputs
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mod2_d  = mod2_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = GEN_F;
               idx_d   = '0;
               mod2_d  = 1'b0;
            end
         end
         GEN_F, GEN_G: begin
            if (acc) begin
               if (last) begin
                  state_d = (state_q == GEN_F) ?
                            GEN_G : FIN;
                  idx_d   = '0;
                  mod2_d  = 1'b0;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  mod2_d = mod2_q ^ s[0];
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.abort) begin
         state_d = IDLE;
         idx_d   = '0;
         mod2_d  = 1'b0;
      end

      busy_d = (state_d != IDLE);
      ena_d  = (state_d == GEN_F) ||
               (state_d == GEN_G);
      done_d = (state_q == FIN) && !bus.abort;
      we_d   = acc;
      sel_d  = acc ? (state_q == GEN_G) : sel_q;
      addr_d = acc ? idx_q : addr_q;
      data_d = acc ? s[COEF_W-1:0] : data_q;
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mod2_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ena_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mod2_q  <= mod2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ena_q   <= ena_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.gauss_ena = ena_q;
   assign bus.coef_we   = we_q;
   assign bus.coef_sel  = sel_q;
   assign bus.coef_addr = addr_q;
   assign bus.coef_data = data_q;

`ifdef FG_SAMPLER_STATS_EN
   logic        rej;
   logic        start_acc;
   logic [15:0] rej_q;

   assign rej       = in_gen && bus.gauss_val_valid && !acc;
   assign start_acc = (state_q == IDLE) && bus.start &&
                      !bus.abort;

   // saturating reject counter, cleared by an accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rej_q <= '0;
      else if (start_acc)
         rej_q <= '0;
      else if (rej && (rej_q != 16'hFFFF))
         rej_q <= rej_q + 16'd1;
   end

   assign rej_cnt = rej_q;
`endif

endmodule

// File: tb/tb_fg_sampler_ctrl.sv
// tb_fg_sampler_ctrl: directed bench, LOGN=1 and LOGN=9 instances
// FG_SAMPLER_STATS_EN also checks rej_cnt
module tb_fg_sampler_ctrl;

   logic clk = 1'b0;
   logic rst1_n;
   logic rst9_n;

   always #5 clk = ~clk;

   fg_sampler_ctrl_if #(.LOGN(1), .COEF_W(8)) b1 ();
   fg_sampler_ctrl_if #(.LOGN(9), .COEF_W(8)) b9 ();

`ifdef FG_SAMPLER_STATS_EN
   logic [15:0] rc1;
   logic [15:0] rc9;
`endif

   fg_sampler_ctrl #(.LOGN(1), .COEF_W(8)) u1 (
      .clk   (clk),
      .rst_n (rst1_n),
      .bus   (b1)
`ifdef FG_SAMPLER_STATS_EN
      ,
      .rej_cnt (rc1)
`endif
   );

   fg_sampler_ctrl #(.LOGN(9), .COEF_W(8)) u9 (
      .clk   (clk),
      .rst_n (rst9_n),
      .bus   (b9)
`ifdef FG_SAMPLER_STATS_EN
      ,
      .rej_cnt (rc9)
`endif
   );

   int checks = 0;
   int errors = 0;
   int done1  = 0;
   int done9  = 0;
   logic [9:0] log1[$];

   // write/done monitor on the falling edge
   always @(negedge clk) begin
      if (b1.coef_we)
         log1.push_back({b1.coef_sel, b1.coef_addr,
                         b1.coef_data});
      if (b1.done) done1++;
      if (b9.done) done9++;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic start1;
      b1.start = 1'b1;
      step();
      b1.start = 1'b0;
   endtask

   task automatic start9;
      b9.start = 1'b1;
      step();
      b9.start = 1'b0;
   endtask

   task automatic feed1(input logic [31:0] v);
      b1.gauss_val_valid = 1'b1;
      b1.gauss_val       = v;
      step();
   endtask

   task automatic feed9(input logic [31:0] v);
      b9.gauss_val_valid = 1'b1;
      b9.gauss_val       = v;
      step();
   endtask

   task automatic expect_log(input string tag,
                             input logic [9:0] e0,
                             input logic [9:0] e1,
                             input logic [9:0] e2,
                             input logic [9:0] e3);
      logic [9:0] e[4];
      logic [9:0] g;
      e = '{e0, e1, e2, e3};
      check({tag, "_n"}, log1.size(), 4);
      for (int i = 0; i < 4; i++) begin
         g = (i < log1.size()) ? log1[i] : 10'h3FF;
         check($sformatf("%s_w%0d", tag, i), g, e[i]);
      end
   endtask

   initial begin
      rst1_n = 1'b0;
      rst9_n = 1'b0;
      b1.start = 0; b1.abort = 0;
      b1.gauss_val_valid = 0; b1.gauss_val = '0;
      b9.start = 0; b9.abort = 0;
      b9.gauss_val_valid = 0; b9.gauss_val = '0;
      step();
      step();
      check("rst_busy", b1.busy, 0);
      check("rst_done", b1.done, 0);
      check("rst_ena",  b1.gauss_ena, 0);
      check("rst_we",   b1.coef_we, 0);
      check("rst_sel",  b1.coef_sel, 0);
      check("rst_addr", b9.coef_addr, 0);
      check("rst_data", b9.coef_data, 0);
      rst1_n = 1'b1;
      rst9_n = 1'b1;
      step();

      // f={3,4} g={-5,6}
      log1.delete();
      start1();
      check("t1_busy", b1.busy, 1);
      check("t1_ena",  b1.gauss_ena, 1);
      feed1(3);
      check("t1_we0",   b1.coef_we, 1);
      check("t1_data0", b1.coef_data, 8'h03);
      feed1(4);
      feed1(-5);
      check("t1_sel2",  b1.coef_sel, 1);
      check("t1_ena2",  b1.gauss_ena, 1);
      feed1(6);
      check("t1_we3",   b1.coef_we, 1);
      check("t1_addr3", b1.coef_addr, 1);
      check("t1_data3", b1.coef_data, 8'h06);
      check("t1_enaF",  b1.gauss_ena, 0);
      check("t1_busyF", b1.busy, 1);
      check("t1_doneF", b1.done, 0);
      feed1(7);
      check("t1_done",  b1.done, 1);
      check("t1_busyD", b1.busy, 0);
      check("t1_weD",   b1.coef_we, 0);
      b1.gauss_val_valid = 0;
      step();
      check("t1_pulse", b1.done, 0);
      step();
      expect_log("t1", 10'h003, 10'h104,
                 10'h2FB, 10'h306);
      check("t1_ndone", done1, 1);

      // parity reject on last f, start while busy ignored
      log1.delete();
      start1();
      feed1(1);
      b1.start = 1'b1;
      feed1(1);
      b1.start = 1'b0;
      check("t3_rej_we", b1.coef_we, 0);
      feed1(2);
      feed1(1);
      feed1(2);
      b1.gauss_val_valid = 0;
      step();
      step();
      expect_log("t3", 10'h001, 10'h102,
                 10'h201, 10'h302);
      check("t3_ndone", done1, 2);
`ifdef FG_SAMPLER_STATS_EN
      check("t3_rej", rc1, 1);
`endif

      // start and abort together: abort wins
      b1.start = 1'b1;
      b1.abort = 1'b1;
      step();
      b1.start = 1'b0;
      b1.abort = 1'b0;
      check("sa_busy", b1.busy, 0);
      check("sa_ena",  b1.gauss_ena, 0);
      step();
      check("sa_busy2", b1.busy, 0);

      // async reset mid-GEN_F, then full refill
      start1();
      feed1(3);
      b1.gauss_val_valid = 0;
      check("rm_we1", b1.coef_we, 1);
      #1 rst1_n = 1'b0;
      #1;
      check("rm_busy", b1.busy, 0);
      check("rm_ena",  b1.gauss_ena, 0);
      check("rm_we",   b1.coef_we, 0);
      check("rm_data", b1.coef_data, 0);
      step();
      rst1_n = 1'b1;
      step();
      log1.delete();
      start1();
      feed1(3);
      feed1(4);
      feed1(-5);
      feed1(6);
      b1.gauss_val_valid = 0;
      step();
      step();
      expect_log("rm", 10'h003, 10'h104,
                 10'h2FB, 10'h306);
      check("rm_ndone", done1, 3);

      // LOGN=9: 32 out of bound, 31 accepted
      start9();
      feed9(32);
      check("b9_rej_we", b9.coef_we, 0);
      feed9(31);
      check("b9_we",   b9.coef_we, 1);
      check("b9_addr", b9.coef_addr, 0);
      check("b9_data", b9.coef_data, 8'h1F);
`ifdef FG_SAMPLER_STATS_EN
      check("b9_rej", rc9, 1);
`endif
      // mod2=1 so zeros complete f with odd parity
      for (int i = 0; i < 511; i++) feed9(0);
      check("b9_flast_sel",  b9.coef_sel, 0);
      check("b9_flast_addr", b9.coef_addr, 511);
      for (int i = 0; i < 5; i++) feed9(0);
      check("b9_g_sel",  b9.coef_sel, 1);
      check("b9_g_addr", b9.coef_addr, 4);
      check("b9_g_ena",  b9.gauss_ena, 1);
      b9.gauss_val_valid = 0;
      b9.abort = 1'b1;
      step();
      b9.abort = 1'b0;
      check("ab_ena",  b9.gauss_ena, 0);
      check("ab_busy", b9.busy, 0);
      repeat (4) step();
      check("ab_ndone", done9, 0);
      start9();
      check("ab_busy2", b9.busy, 1);
      feed9(7);
      b9.gauss_val_valid = 0;
      check("ab_we",   b9.coef_we, 1);
      check("ab_sel",  b9.coef_sel, 0);
      check("ab_addr", b9.coef_addr, 0);
      check("ab_data", b9.coef_data, 8'h07);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
